// File: rtl/pixel_stream_pkg.sv
// Shared types for the pixel stream framer: FIFO entry layout and framing FSM states.
// Pure type definitions; no latency or backpressure of their own.
package pixel_stream_pkg;

  localparam int PIX_DATA_W = 32;

  typedef struct packed {
    logic                  last;
    logic [PIX_DATA_W-1:0] data;
  } fifo_entry_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } framer_state_t;

endpackage

// File: rtl/pixel_stream_framer_if.sv
// Valid/ready stream bundle; master drives valid/data/last and slave drives ready.
// The upstream side carries no last, so the slave modport omits it.
interface pixel_stream_framer_if
  import pixel_stream_pkg::*;
#(
  parameter int DATA_W = PIX_DATA_W
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/framer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO reporting occupancy, full and empty.
// Write visible at the head the next cycle; the caller must never push when full without a pop.
module framer_sync_fifo #(
  parameter  int W     = 33,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          axi_clk,
  input  logic          axi_reset_n,
  input  logic          push,
  input  logic [W-1:0]  wr_dat,
  input  logic          pop,
  output logic [W-1:0]  rd_dat,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: empty gates every use of the head downstream.
  always_ff @(posedge axi_clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  assign rd_dat = mem[rd_ptr];
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);

endmodule

// File: rtl/pixel_stream_framer.sv
// Elastic re-framer between the pixel inverter and S2MM DMA; FWFT, 1-cycle latency, ready drops with 2 slots spare.
// Build option PIXEL_FRAMER_STATS_EN adds a 16-bit completed-frame counter on frame_count.
module pixel_stream_framer
  import pixel_stream_pkg::*;
#(
  parameter int DATA_W = PIX_DATA_W,
  parameter int LEN_W  = 20,
  parameter int DEPTH  = 4
) (
  input  logic                   axi_clk,
  input  logic                   axi_reset_n,
  input  logic [LEN_W-1:0]       frame_words,
  pixel_stream_framer_if.slave   s_axis,
  pixel_stream_framer_if.master  m_axis,
  output logic                   frame_done,
  output logic                   overflow,
  output logic [15:0]            frame_count
);

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  RDY_THR = CW'(DEPTH - 3);

  fifo_entry_t     wr_entry;
  fifo_entry_t     rd_entry;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            rdy_q;

  framer_state_t   state;
  framer_state_t   state_next;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_next;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_next;
  logic [LEN_W-1:0] len_eff;

  // Writes ignore s_axis.ready so the inverter's late valid still lands; a pop frees a full slot first.
  assign pop        = !empty && m_axis.ready;
  assign push       = s_axis.valid && (!full || pop);
  assign count_next = count + CW'(push) - CW'(pop);

  framer_sync_fifo #(
    .W     ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .axi_clk     (axi_clk),
    .axi_reset_n (axi_reset_n),
    .push        (push),
    .wr_dat      (wr_entry),
    .pop         (pop),
    .rd_dat      (rd_entry),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    len_next       = len;
    len_eff        = (frame_words == '0) ? LEN_W'(1) : frame_words;
    wr_entry.data  = s_axis.data;
    wr_entry.last  = 1'b0;
    case (state)
      IDLE: begin
        if (push) begin
          wr_entry.last = (len_eff == LEN_W'(1));
          if (len_eff != LEN_W'(1)) begin
            len_next   = len_eff;
            cnt_next   = LEN_W'(1);
            state_next = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        if (push) begin
          wr_entry.last = (cnt == len - LEN_W'(1));
          if (cnt == len - LEN_W'(1)) begin
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next   = cnt + LEN_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      len      <= '0;
      rdy_q    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      len   <= len_next;
      rdy_q <= (count_next <= RDY_THR);
      if (s_axis.valid && !push) overflow <= 1'b1;
    end
  end

  assign s_axis.ready = rdy_q;
  assign m_axis.valid = !empty;
  assign m_axis.data  = empty ? '0 : rd_entry.data;
  assign m_axis.last  = !empty && rd_entry.last;
  assign frame_done   = pop && rd_entry.last;

`ifdef PIXEL_FRAMER_STATS_EN
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n)    frame_count <= '0;
    else if (frame_done) frame_count <= frame_count + 16'd1;
  end
`else
  assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_pixel_stream_framer.sv
// Directed bench for pixel_stream_framer: framing, handshake margin, overflow, zero-length and mid-frame reset.
// Downstream beats are captured on the falling edge and compared with hand-computed values.
module tb_pixel_stream_framer;
  import pixel_stream_pkg::*;

  logic        axi_clk;
  logic        axi_reset_n;
  logic [19:0] frame_words;
  logic        frame_done;
  logic        overflow;
  logic [15:0] frame_count;

  int errors;
  int checks;
  int done_cnt;
  int n;

  logic [31:0] got_dat[$];
  logic        got_last[$];

  pixel_stream_framer_if #(.DATA_W(32)) s_if ();
  pixel_stream_framer_if #(.DATA_W(32)) m_if ();

  pixel_stream_framer #(
    .DATA_W (32),
    .LEN_W  (20),
    .DEPTH  (4)
  ) dut (
    .axi_clk     (axi_clk),
    .axi_reset_n (axi_reset_n),
    .frame_words (frame_words),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .frame_count (frame_count)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  always @(negedge axi_clk) begin
    if (axi_reset_n) begin
      if (m_if.valid && m_if.ready) begin
        got_dat.push_back(m_if.data);
        got_last.push_back(m_if.last);
      end
      if (frame_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [31:0] d, input logic l);
    logic [31:0] od;
    logic        ol;
    od = 'x;
    ol = 1'bx;
    if (idx < got_dat.size()) begin
      od = got_dat[idx];
      ol = got_last[idx];
    end
    chk($sformatf("%s_dat%0d", tag, idx), od, d);
    chk($sformatf("%s_last%0d", tag, idx), ol, l);
  endtask

  task automatic clear_capture();
    got_dat.delete();
    got_last.delete();
    done_cnt = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, s_if.ready, 1'b0);
    chk({tag, "_m_valid"}, m_if.valid, 1'b0);
    chk({tag, "_m_data"}, m_if.data, 32'h0);
    chk({tag, "_m_last"}, m_if.last, 1'b0);
    chk({tag, "_done"}, frame_done, 1'b0);
    chk({tag, "_overflow"}, overflow, 1'b0);
    chk({tag, "_fcount"}, frame_count, 16'd0);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    done_cnt    = 0;
    axi_reset_n = 1'b0;
    frame_words = 20'd4;
    s_if.valid  = 1'b0;
    s_if.data   = '0;
    s_if.last   = 1'b0;
    m_if.ready  = 1'b0;

    // Reset state and ready rising one cycle after release
    tick();
    tick();
    chk_all_zero("rst");
    axi_reset_n = 1'b1;
    #1;
    chk("rst_rel_ready_low", s_if.ready, 1'b0);
    tick();
    chk("rst_rel_ready_high", s_if.ready, 1'b1);

    // 1: two 4-word frames streamed with downstream always ready
    clear_capture();
    m_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = 32'h1000_0000 + i;
      tick();
    end
    s_if.valid = 1'b0;
    repeat (4) tick();
    chk("t1_beats", got_dat.size(), 8);
    for (int i = 0; i < 8; i++) chk_beat("t1", i, 32'h1000_0000 + i, (i == 3) || (i == 7));
    chk("t1_done", done_cnt, 2);
    chk("t1_overflow", overflow, 1'b0);
`ifdef PIXEL_FRAMER_STATS_EN
    chk("t1_fcount", frame_count, 16'd2);
`else
    chk("t1_fcount", frame_count, 16'd0);
`endif

    // 2: stalled sink, upstream keeps valid through the late window
    clear_capture();
    m_if.ready = 1'b0;
    n = 0;
    s_if.valid = 1'b1;
    s_if.data  = 32'h2000_0000;
    for (int k = 0; k < 10; k++) begin
      tick();
      n++;
      s_if.data = 32'h2000_0000 + n;
      if (!s_if.ready) break;
    end
    chk("t2_ready_fall_beats", n, 2);
    tick();
    s_if.data = 32'h2000_0003;
    tick();
    s_if.valid = 1'b0;
    #1;
    chk("t2_ready_held_low", s_if.ready, 1'b0);
    chk("t2_overflow", overflow, 1'b0);
    chk("t2_head_held", m_if.data, 32'h2000_0000);
    m_if.ready = 1'b1;
    repeat (8) tick();
    chk("t2_beats", got_dat.size(), 4);
    for (int i = 0; i < 4; i++) chk_beat("t2", i, 32'h2000_0000 + i, i == 3);
    chk("t2_done", done_cnt, 1);
    chk("t2_ready_back", s_if.ready, 1'b1);
`ifdef PIXEL_FRAMER_STATS_EN
    chk("t2_fcount", frame_count, 16'd3);
`else
    chk("t2_fcount", frame_count, 16'd0);
`endif

    // 3: valid forced for 6 cycles into a stalled sink
    clear_capture();
    m_if.ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = 32'h3000_0000 + i;
      tick();
    end
    s_if.valid = 1'b0;
    #1;
    chk("t3_overflow", overflow, 1'b1);
    chk("t3_m_valid", m_if.valid, 1'b1);
    chk("t3_head", m_if.data, 32'h3000_0000);
    repeat (3) tick();
    chk("t3_overflow_sticky", overflow, 1'b1);
    m_if.ready = 1'b1;
    repeat (8) tick();
    chk("t3_beats", got_dat.size(), 4);
    for (int i = 0; i < 4; i++) chk_beat("t3", i, 32'h3000_0000 + i, i == 3);
    chk("t3_done", done_cnt, 1);
    chk("t3_overflow_after", overflow, 1'b1);

    // 4: zero frame length means single-word frames
    clear_capture();
    frame_words = 20'd0;
    for (int i = 0; i < 3; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = 32'h4000_0000 + i;
      tick();
    end
    s_if.valid = 1'b0;
    repeat (4) tick();
    chk("t4_beats", got_dat.size(), 3);
    for (int i = 0; i < 3; i++) chk_beat("t4", i, 32'h4000_0000 + i, 1'b1);
    chk("t4_done", done_cnt, 3);

    // 5: frame length changed mid-frame takes effect on the next frame only
    clear_capture();
    frame_words = 20'd4;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) frame_words = 20'd2;
      s_if.valid = 1'b1;
      s_if.data  = 32'h5000_0000 + i;
      tick();
    end
    s_if.valid = 1'b0;
    repeat (4) tick();
    chk("t5_beats", got_dat.size(), 6);
    for (int i = 0; i < 6; i++) chk_beat("t5", i, 32'h5000_0000 + i, (i == 3) || (i == 5));
    chk("t5_done", done_cnt, 2);

    // 6: reset during beat 3 of a 4-word frame with data queued
    clear_capture();
    frame_words = 20'd4;
    m_if.ready  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = 32'h6000_0000 + i;
      tick();
    end
    s_if.data = 32'h6000_0002;
    chk("t6_pre_valid", m_if.valid, 1'b1);
    #2;
    axi_reset_n = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    s_if.valid = 1'b0;
    tick();
    tick();
    axi_reset_n = 1'b1;
    tick();
    chk("t6_rel_ready", s_if.ready, 1'b1);
    chk("t6_rel_empty", m_if.valid, 1'b0);
    m_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = 32'h6100_0000 + i;
      tick();
    end
    s_if.valid = 1'b0;
    repeat (4) tick();
    chk("t6_beats", got_dat.size(), 4);
    for (int i = 0; i < 4; i++) chk_beat("t6", i, 32'h6100_0000 + i, i == 3);
    chk("t6_done", done_cnt, 1);
`ifdef PIXEL_FRAMER_STATS_EN
    chk("t6_fcount", frame_count, 16'd1);
`else
    chk("t6_fcount", frame_count, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
